wb_stage_param: RTL and testbench
=================================

Name: wb_stage_param

Overview:
- Parametrised write-back stage for the CPU pipeline. Sits between the MEM/WB pipeline buffer and the register-file write port.
- Selects the ALU result or the formatted load data (byte/half/word/double, sign- or zero-extended, byte-offset aligned).
- Holds the result in a valid/ready output register. Drives a forwarding tap and a retire counter.
- Generalises the fixed 64-bit, 5-bit-register write-back: adds width parameters, back-pressure, load formatting, x0 suppression and misalignment flagging.

Parameters:
- DATA_W, 64, datapath width; legal values 32 or 64.
- REG_AW, 5, register address width.
- ZERO_REG, 1, when 1, writes to register 0 are suppressed.
- CNT_W, 32, retire counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  MEM/WB entry valid.
- in_ready  out  1  stage can accept an entry this cycle.
- in_rd  in  REG_AW  destination register.
- in_result  in  DATA_W  ALU result.
- in_load_data  in  DATA_W  raw memory read data.
- in_mem_to_reg  in  1  1 = select load data.
- in_reg_write  in  1  entry writes the register file.
- in_load_size  in  2  0 byte, 1 half, 2 word, 3 double.
- in_load_unsigned  in  1  1 = zero-extend.
- in_byte_off  in  log2(DATA_W/8)  byte offset of the load within in_load_data.
- wb_valid  out  1  output entry valid.
- wb_ready  in  1  register file accepts the entry.
- wb_we  out  1  register write enable (qualified).
- wb_rd  out  REG_AW  register to write.
- wb_data  out  DATA_W  data to write.
- misalign_err  out  1  one-cycle pulse when an accepted load is misaligned.
- fwd_valid  out  1  forwarding tap valid.
- fwd_rd  out  REG_AW  forwarding register.
- fwd_data  out  DATA_W  forwarding data.
- retire_cnt  out  CNT_W  count of completed register writes.

Behaviour:
- Reset (async, rst_n=0): all outputs are 0.
  - Covers wb_valid, wb_we, wb_rd, wb_data, misalign_err, fwd_*, retire_cnt.
  - in_ready is 1 immediately after reset, because the output register is empty.
- Accept rule: accept = in_valid & in_ready; in_ready = !wb_valid | wb_ready. The ready path is combinational; there is no skid buffer.
- Latency: one cycle. An entry accepted at edge N appears on the wb_* outputs after edge N. It holds stable while wb_valid & !wb_ready.
- Complete rule: complete = wb_valid & wb_ready.
  - Complete with no accept in the same cycle: wb_valid clears next edge.
  - Complete and accept in the same cycle: the new entry replaces the old with no bubble.
- wb_we = in_reg_write & !(ZERO_REG & in_rd==0), captured at accept.
- Data select:
  - in_mem_to_reg=0: wb_data = in_result.
  - in_mem_to_reg=1: shifted = in_load_data >> (8*in_byte_off). Take the low 8/16/32/64 bits per size, then sign- or zero-extend to DATA_W.
  - When DATA_W=32, size 3 is treated as size 2.
- Misalignment: applies when in_mem_to_reg=1 and in_byte_off is not a multiple of the access size in bytes.
  - misalign_err pulses for exactly one cycle, on the cycle after accept.
  - The data is still formed from the shifted bits. No write suppression.
- Forwarding tap:
  - fwd_valid = wb_valid & wb_we; fwd_rd = wb_rd; fwd_data = wb_data.
  - Combinational from the output register, so it is valid during stalls.
- retire_cnt increments by 1 on each complete with wb_we=1. It wraps modulo 2^CNT_W.
- Reset mid-stall: the held entry is discarded, no write occurs, and the counter clears.
- wb_ready=1 while wb_valid=0 has no effect.

Decomposition:
- Shared package cpu_pkg:
  - load-size encoding constants: LS_BYTE, LS_HALF, LS_WORD, LS_DOUBLE.
  - default DATA_W and REG_AW.
  - a typedef for the MEM/WB entry fields, replacing the flat 135-bit buffer.
- One sub-module, load_align, is natural: purely combinational shift, extract and extend, plus the misalign check.
- Top level holds the output register, handshake, counter and forwarding tap.

Test Plan:
- Reset then ALU write: rd=7, result=0x1234, mem_to_reg=0, reg_write=1, wb_ready=1.
  - Next cycle: wb_valid=1, wb_we=1, wb_rd=7, wb_data=0x1234.
  - Cycle after: retire_cnt=1.
- Signed byte load: load_data=0x00000000_0000F000, off=1, size=0, unsigned=0 -> wb_data=0xFFFFFFFF_FFFFFFF0. Same entry with unsigned=1 -> wb_data=0xF0.
- Back-pressure: hold wb_ready=0 for 3 cycles with in_valid=1.
  - in_ready=0 throughout and wb_* stable.
  - Release: the two queued entries complete on consecutive cycles with no bubble; retire_cnt=+2.
- x0 suppression: rd=0, reg_write=1 -> wb_valid=1, wb_we=0, fwd_valid=0, retire_cnt unchanged.
- Misaligned half load: size=1, off=3 -> misalign_err=1 for one cycle; wb_data = sign-extended bytes 3..4.
- Async reset asserted while wb_valid=1 & wb_ready=0 -> all outputs 0 immediately; in_ready=1 after release; no write issued.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: load-size encoding, default widths and the
// MEM/WB entry record that replaces the old flat pipeline buffer.
package cpu_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    LS_BYTE   = 2'd0,
    LS_HALF   = 2'd1,
    LS_WORD   = 2'd2,
    LS_DOUBLE = 2'd3
  } load_size_e;

  typedef struct packed {
    logic [REG_AW_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] result;
    logic [DATA_W_DEF-1:0] load_data;
    logic                  mem_to_reg;
    logic                  reg_write;
    load_size_e            load_size;
    logic                  load_unsigned;
    logic [2:0]            byte_off;
  } memwb_entry_t;

  function automatic int unsigned size_bytes(load_size_e s);
    return 32'd1 << s;
  endfunction

endpackage

// File: rtl/wb_stage_param_if.sv
// MEM/WB-to-register-file handshake bundle for the write-back stage.
// The stage itself uses the slave view; the surrounding pipeline uses master.
interface wb_stage_param_if #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rd;
  logic [DATA_W-1:0] in_result;
  logic [DATA_W-1:0] in_load_data;
  logic              in_mem_to_reg;
  logic              in_reg_write;
  logic [1:0]        in_load_size;
  logic              in_load_unsigned;
  logic [OFF_W-1:0]  in_byte_off;

  logic              wb_valid;
  logic              wb_ready;
  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  modport slave (
    input  in_valid, in_rd, in_result, in_load_data, in_mem_to_reg,
           in_reg_write, in_load_size, in_load_unsigned, in_byte_off, wb_ready,
    output in_ready, wb_valid, wb_we, wb_rd, wb_data
  );

  modport master (
    output in_valid, in_rd, in_result, in_load_data, in_mem_to_reg,
           in_reg_write, in_load_size, in_load_unsigned, in_byte_off, wb_ready,
    input  in_ready, wb_valid, wb_we, wb_rd, wb_data
  );
endinterface

// File: rtl/wb_stage_param_load_align.sv
// Load formatter: shifts raw read data down by the byte offset, extracts the
// access width, sign/zero-extends it and flags offsets not aligned to the size.
module wb_stage_param_load_align
  import cpu_pkg::*;
#(
  parameter int DATA_W = 64,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] load_data,
  input  logic [1:0]        load_size,
  input  logic              load_unsigned,
  input  logic [OFF_W-1:0]  byte_off,
  output logic [DATA_W-1:0] data,
  output logic              misalign
);

  load_size_e        eff_size;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] hi_mask;
  logic              msb;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    eff_size = load_size_e'(load_size);
    shifted  = load_data >> {byte_off, 3'b000};
    hi_mask  = '0;
    msb      = 1'b0;

    // A 32-bit datapath has no double access; it degrades to a word.
    if (DATA_W == 32 && eff_size == LS_DOUBLE) eff_size = LS_WORD;

    case (eff_size)
      LS_BYTE: begin
        msb     = shifted[7];
        hi_mask = {DATA_W{1'b1}} << 8;
      end
      LS_HALF: begin
        msb     = shifted[15];
        hi_mask = {DATA_W{1'b1}} << 16;
      end
      LS_WORD: begin
        msb     = shifted[31];
        hi_mask = {DATA_W{1'b1}} << 32;
      end
      default: begin
        msb     = shifted[DATA_W-1];
        hi_mask = '0;
      end
    endcase

    data     = (msb && !load_unsigned) ? (shifted | hi_mask) : (shifted & ~hi_mask);
    misalign = |(byte_off & OFF_W'(size_bytes(eff_size) - 1));
  end

endmodule

// File: rtl/wb_stage_param.sv
// Write-back stage: one-entry valid/ready output register feeding the register
// file, with load formatting, x0 suppression, forwarding tap and retire count.
module wb_stage_param
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_stage_param_if.slave   bus,
  output logic              misalign_err,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } out_reg_t;

  out_reg_t          out_q;
  logic              mis_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [DATA_W-1:0] load_fmt;
  logic              load_mis;
  logic              accept;
  logic              complete;
  logic              we_next;

  wb_stage_param_load_align #(.DATA_W(DATA_W)) u_align (
    .load_data     (bus.in_load_data),
    .load_size     (bus.in_load_size),
    .load_unsigned (bus.in_load_unsigned),
    .byte_off      (bus.in_byte_off),
    .data          (load_fmt),
    .misalign      (load_mis)
  );

  // Ready is combinational from the output register: no skid buffer, so a
  // completing entry frees the slot in the same cycle.
  assign bus.in_ready = !out_q.valid || bus.wb_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign complete     = out_q.valid && bus.wb_ready;
  assign we_next      = bus.in_reg_write && !((ZERO_REG != 0) && (bus.in_rd == '0));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      mis_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        out_q.valid <= 1'b1;
        out_q.we    <= we_next;
        out_q.rd    <= bus.in_rd;
        out_q.data  <= bus.in_mem_to_reg ? load_fmt : bus.in_result;
      end else if (complete) begin
        out_q.valid <= 1'b0;
      end
      mis_q <= accept && bus.in_mem_to_reg && load_mis;
      if (complete && out_q.we) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.wb_valid = out_q.valid;
  assign bus.wb_we    = out_q.valid && out_q.we;
  assign bus.wb_rd    = out_q.rd;
  assign bus.wb_data  = out_q.data;

  assign misalign_err = mis_q;
  assign fwd_valid    = out_q.valid && out_q.we;
  assign fwd_rd       = out_q.rd;
  assign fwd_data     = out_q.data;
  assign retire_cnt   = cnt_q;

endmodule

// File: tb/tb_wb_stage_param.sv
// Self-checking bench for wb_stage_param: table of single-entry vectors plus
// hand-written back-pressure, x0 and reset-during-stall sequences.
module tb_wb_stage_param;
  import cpu_pkg::*;

  localparam int DATA_W = 64;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;

  logic clk;
  logic rst_n;
  logic              misalign_err;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_rd;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  retire_cnt;

  wb_stage_param_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  wb_stage_param #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_REG(1), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .misalign_err (misalign_err),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
    .retire_cnt   (retire_cnt)
  );

  typedef struct {
    memwb_entry_t e;
    logic [63:0]  exp_data;
    logic         exp_we;
    logic         exp_mis;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int unsigned exp_cnt = 0;
  vec_t vecs[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic memwb_entry_t mk(input logic [4:0] rd, input logic [63:0] result,
                                      input logic [63:0] ld, input logic m2r,
                                      input logic rw, input load_size_e sz,
                                      input logic uns, input logic [2:0] off);
    memwb_entry_t e;
    e.rd = rd; e.result = result; e.load_data = ld; e.mem_to_reg = m2r;
    e.reg_write = rw; e.load_size = sz; e.load_unsigned = uns; e.byte_off = off;
    return e;
  endfunction

  task automatic drive(input memwb_entry_t e, input logic v);
    bus.in_valid         = v;
    bus.in_rd            = e.rd;
    bus.in_result        = e.result;
    bus.in_load_data     = e.load_data;
    bus.in_mem_to_reg    = e.mem_to_reg;
    bus.in_reg_write     = e.reg_write;
    bus.in_load_size     = e.load_size;
    bus.in_load_unsigned = e.load_unsigned;
    bus.in_byte_off      = e.byte_off;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wb_valid"}, 64'(bus.wb_valid), 64'd0);
    check({tag, "_wb_we"},    64'(bus.wb_we),    64'd0);
    check({tag, "_wb_rd"},    64'(bus.wb_rd),    64'd0);
    check({tag, "_wb_data"},  bus.wb_data,       64'd0);
    check({tag, "_mis"},      64'(misalign_err), 64'd0);
    check({tag, "_fwd_v"},    64'(fwd_valid),    64'd0);
    check({tag, "_fwd_rd"},   64'(fwd_rd),       64'd0);
    check({tag, "_fwd_data"}, fwd_data,          64'd0);
    check({tag, "_cnt"},      64'(retire_cnt),   64'd0);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    memwb_entry_t idle;
    idle = mk(5'd0, 64'd0, 64'd0, 1'b0, 1'b0, LS_BYTE, 1'b0, 3'd0);

    vecs.push_back('{mk(5'd7, 64'h1234, 64'd0, 1'b0, 1'b1, LS_BYTE, 1'b0, 3'd0), 64'h1234, 1'b1, 1'b0});
    vecs.push_back('{mk(5'd3, 64'd0, 64'h0000_0000_0000_F000, 1'b1, 1'b1, LS_BYTE, 1'b0, 3'd1), 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b0});
    vecs.push_back('{mk(5'd3, 64'd0, 64'h0000_0000_0000_F000, 1'b1, 1'b1, LS_BYTE, 1'b1, 3'd1), 64'h0000_0000_0000_00F0, 1'b1, 1'b0});
    vecs.push_back('{mk(5'd0, 64'h55, 64'd0, 1'b0, 1'b1, LS_BYTE, 1'b0, 3'd0), 64'h55, 1'b0, 1'b0});
    vecs.push_back('{mk(5'd9, 64'd0, 64'h0000_0080_1100_0000, 1'b1, 1'b1, LS_HALF, 1'b0, 3'd3), 64'hFFFF_FFFF_FFFF_8011, 1'b1, 1'b1});
    vecs.push_back('{mk(5'd10, 64'd0, 64'h89AB_CDEF_0000_0000, 1'b1, 1'b1, LS_WORD, 1'b1, 3'd4), 64'h0000_0000_89AB_CDEF, 1'b1, 1'b0});
    vecs.push_back('{mk(5'd10, 64'd0, 64'h89AB_CDEF_0000_0000, 1'b1, 1'b1, LS_WORD, 1'b0, 3'd4), 64'hFFFF_FFFF_89AB_CDEF, 1'b1, 1'b0});
    vecs.push_back('{mk(5'd11, 64'd0, 64'h8000_0000_0000_0001, 1'b1, 1'b1, LS_DOUBLE, 1'b0, 3'd0), 64'h8000_0000_0000_0001, 1'b1, 1'b0});
    vecs.push_back('{mk(5'd11, 64'd0, 64'h8000_0000_0000_0001, 1'b1, 1'b1, LS_DOUBLE, 1'b0, 3'd4), 64'h0000_0000_8000_0000, 1'b1, 1'b1});
    vecs.push_back('{mk(5'd12, 64'd0, 64'h0000_0000_BEEF_0000, 1'b1, 1'b1, LS_HALF, 1'b1, 3'd2), 64'h0000_0000_0000_BEEF, 1'b1, 1'b0});
    vecs.push_back('{mk(5'd13, 64'd0, 64'h0000_1234_5678_0000, 1'b1, 1'b1, LS_WORD, 1'b0, 3'd2), 64'h0000_0000_1234_5678, 1'b1, 1'b1});
    vecs.push_back('{mk(5'd14, 64'd0, 64'h7F00_0000_0000_0000, 1'b1, 1'b1, LS_BYTE, 1'b0, 3'd7), 64'h0000_0000_0000_007F, 1'b1, 1'b0});
    vecs.push_back('{mk(5'd15, 64'hABCD, 64'd0, 1'b0, 1'b0, LS_BYTE, 1'b0, 3'd0), 64'hABCD, 1'b0, 1'b0});
    vecs.push_back('{mk(5'd16, 64'hDEAD, 64'hFFFF, 1'b0, 1'b1, LS_HALF, 1'b0, 3'd3), 64'hDEAD, 1'b1, 1'b0});

    // Reset state
    rst_n = 1'b0;
    drive(idle, 1'b0);
    bus.wb_ready = 1'b0;
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;

    // wb_ready high with nothing held changes nothing
    bus.wb_ready = 1'b1;
    step(); step();
    check("idle_ready_valid", 64'(bus.wb_valid), 64'd0);
    check("idle_ready_cnt",   64'(retire_cnt),   64'd0);

    // Table-driven single entries
    foreach (vecs[i]) begin
      drive(vecs[i].e, 1'b1);
      step();
      drive(idle, 1'b0);
      check($sformatf("v%0d_valid", i), 64'(bus.wb_valid), 64'd1);
      check($sformatf("v%0d_rd", i),    64'(bus.wb_rd),    64'(vecs[i].e.rd));
      check($sformatf("v%0d_data", i),  bus.wb_data,       vecs[i].exp_data);
      check($sformatf("v%0d_we", i),    64'(bus.wb_we),    64'(vecs[i].exp_we));
      check($sformatf("v%0d_fwd", i),   64'(fwd_valid),    64'(vecs[i].exp_we));
      check($sformatf("v%0d_mis", i),   64'(misalign_err), 64'(vecs[i].exp_mis));
      if (vecs[i].exp_we) exp_cnt++;
      step();
      check($sformatf("v%0d_drain_valid", i), 64'(bus.wb_valid),  64'd0);
      check($sformatf("v%0d_mis_pulse", i),   64'(misalign_err),  64'd0);
      check($sformatf("v%0d_cnt", i),         64'(retire_cnt),    64'(exp_cnt));
    end

    // Back-pressure: A held for 3 cycles while B waits, then both drain
    bus.wb_ready = 1'b0;
    drive(mk(5'd1, 64'h111, 64'd0, 1'b0, 1'b1, LS_BYTE, 1'b0, 3'd0), 1'b1);
    step();
    drive(mk(5'd2, 64'h222, 64'd0, 1'b0, 1'b1, LS_BYTE, 1'b0, 3'd0), 1'b1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp%0d_in_ready", c), 64'(bus.in_ready), 64'd0);
      check($sformatf("bp%0d_valid", c),    64'(bus.wb_valid), 64'd1);
      check($sformatf("bp%0d_rd", c),       64'(bus.wb_rd),    64'd1);
      check($sformatf("bp%0d_data", c),     bus.wb_data,       64'h111);
      check($sformatf("bp%0d_fwd_rd", c),   64'(fwd_rd),       64'd1);
      step();
    end
    bus.wb_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    drive(idle, 1'b0);
    exp_cnt++;
    check("bp_b_valid", 64'(bus.wb_valid), 64'd1);
    check("bp_b_rd",    64'(bus.wb_rd),    64'd2);
    check("bp_b_data",  bus.wb_data,       64'h222);
    check("bp_cnt_a",   64'(retire_cnt),   64'(exp_cnt));
    step();
    exp_cnt++;
    check("bp_empty",   64'(bus.wb_valid), 64'd0);
    check("bp_cnt_ab",  64'(retire_cnt),   64'(exp_cnt));

    // Reset while an entry is stalled: discarded, counter cleared at once
    bus.wb_ready = 1'b0;
    drive(mk(5'd5, 64'h777, 64'd0, 1'b0, 1'b1, LS_BYTE, 1'b0, 3'd0), 1'b1);
    step();
    drive(idle, 1'b0);
    check("rs_held_valid", 64'(bus.wb_valid), 64'd1);
    check("rs_pre_cnt",    64'(retire_cnt),   64'(exp_cnt));
    rst_n = 1'b0;
    #1;
    check_all_zero("rs");
    #2;
    rst_n = 1'b1;
    bus.wb_ready = 1'b1;
    step();
    check("rs_after_valid", 64'(bus.wb_valid), 64'd0);
    check("rs_after_cnt",   64'(retire_cnt),   64'd0);
    check("rs_after_ready", 64'(bus.in_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
